rec_mem_arbiter: RTL

- Shares the single-port record BRAM between the packet-engine requesters:
  - requester 0: checksum calculator
  - requester 1: data-set writer
  - requester 2: frame sender
- Replaces ad-hoc OR-ing of address/data buses with a request/grant arbiter.
- Round-robin fairness, optional burst lock with watchdog, per-requester read-data valid strobes.
- Sits between the packet FSM/helpers and the bram instance.

---
 rtl/rec_mem_pkg.sv | 29 ++
 rtl/rec_mem_arbiter_rr_pick.sv | 45 ++++
 rtl/rec_mem_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rec_mem_pkg.sv
// rec_mem_pkg: shared definitions for the record-BRAM arbiter.
// Contents: requester ids, default bus widths, FSM state encoding, lock
// counter width and a small modulo-increment helper for the round-robin
// pointer.
package rec_mem_pkg;

  // Requester ids (bit position in the request/grant vectors).
  localparam int REQ_SCS  = 0;  // checksum calculator
  localparam int REQ_SET  = 1;  // data-set writer
  localparam int REQ_SEND = 2;  // frame sender

  // Default BRAM geometry.
  localparam int DEF_AW = 10;
  localparam int DEF_DW = 8;

  // Lock watchdog counter width.
  localparam int LOCK_CNT_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // (idx + 1) mod n, for idx in [0, n-1].
  function automatic int wrap_inc(input int idx, input int n);
    return ((idx + 32'sd1) >= n) ? 32'sd0 : (idx + 32'sd1);
  endfunction

endpackage

// File: rtl/rec_mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Scans the request vector starting at ptr and wrapping modulo NREQ; the
// first asserted request wins.
// Ports:
//   req  in  NREQ  request vector
//   ptr  in  PW    scan start position (0..NREQ-1)
//   gnt  out NREQ  one-hot winner (all zero when no request)
//   idx  out PW    winner index (0 when no request)
module rr_pick
  import rec_mem_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx
);

  logic          found;
  logic          hit;
  int            scan;
  logic [PW-1:0] pos;

  // Rotating priority scan; ptr < 2**PW < 2*NREQ so one wrap subtract suffices.
  always_comb begin
    gnt   = {NREQ{1'b0}};
    idx   = {PW{1'b0}};
    found = 1'b0;
    hit   = 1'b0;
    scan  = 32'sd0;
    pos   = {PW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      scan = int'(ptr) + i;
      scan = (scan >= NREQ) ? (scan - NREQ) : scan;
      pos  = PW'(scan);
      hit  = req[pos] & ~found;
      gnt[pos] = gnt[pos] | hit;
      idx   = hit ? pos : idx;
      found = found | hit;
    end
  end

endmodule

// File: rtl/rec_mem_arbiter.sv
// rec_mem_arbiter: request/grant arbiter for the single-port record BRAM
// shared by the checksum calculator, data-set writer and frame sender.
// Round-robin between requesters, optional burst lock guarded by a
// watchdog, and per-requester read-valid strobes RD_LAT cycles after grant.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req/i_lock/i_we     per-requester request, keep-ownership, write flag
//   i_addr/i_wdata        packed per-requester address / write data
//   o_gnt                 one-hot grant, access happens in the same cycle
//   o_rvalid/o_rdata      read return strobe per requester, shared data
//   o_mem_*/i_mem_rdata   BRAM port
//   o_lock_timeout        one-cycle pulse when a lock is forcibly released
module rec_mem_arbiter
  import rec_mem_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ-1:0]    i_lock,
  input  logic [NREQ-1:0]    i_we,
  input  logic [NREQ*AW-1:0] i_addr,
  input  logic [NREQ*DW-1:0] i_wdata,
  output logic [NREQ-1:0]    o_gnt,
  output logic [NREQ-1:0]    o_rvalid,
  output logic [DW-1:0]      o_rdata,
  output logic               o_mem_en,
  output logic               o_mem_we,
  output logic [AW-1:0]      o_mem_addr,
  output logic [DW-1:0]      o_mem_wdata,
  input  logic [DW-1:0]      i_mem_rdata,
  output logic               o_lock_timeout
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [LOCK_CNT_W-1:0] LOCK_LIM = LOCK_CNT_W'(LOCK_MAX);

  arb_state_t            state;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         owner;
  logic [LOCK_CNT_W-1:0] lock_cnt;
  logic [NREQ-1:0]       rd_pipe [RD_LAT];

  logic [NREQ-1:0]       pick_gnt;
  logic [PW-1:0]         pick_idx;
  logic [NREQ-1:0]       gnt;
  logic [PW-1:0]         sel;
  logic                  timeout;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req (i_req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Grant decision: round-robin when idle, owner-only while locked.
  // Grants are suppressed while reset is asserted so the port stays quiet.
  always_comb begin
    gnt     = {NREQ{1'b0}};
    sel     = pick_idx;
    timeout = 1'b0;
    if (i_rst) begin
      gnt = {NREQ{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          gnt = pick_gnt;
        end
        ST_LOCKED: begin
          sel = owner;
          if (lock_cnt == LOCK_LIM) begin
            // Watchdog cycle: nobody is served, ownership is dropped.
            timeout = 1'b1;
          end else begin
            gnt[owner] = i_req[owner];
          end
        end
        default: begin
          gnt = {NREQ{1'b0}};
        end
      endcase
    end
  end

  // BRAM port mux: the granted requester's slice, zeros when idle.
  always_comb begin
    if (|gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_we[sel];
      o_mem_addr  = i_addr[int'(sel)*AW +: AW];
      o_mem_wdata = i_wdata[int'(sel)*DW +: DW];
    end else begin
      o_mem_en    = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = {AW{1'b0}};
      o_mem_wdata = {DW{1'b0}};
    end
  end

  // Read-return outputs; reset hides any read still in flight.
  always_comb begin
    if (i_rst) begin
      o_rvalid = {NREQ{1'b0}};
    end else begin
      o_rvalid = rd_pipe[RD_LAT-1];
    end
    if (|o_rvalid) begin
      o_rdata = i_mem_rdata;
    end else begin
      o_rdata = {DW{1'b0}};
    end
  end

  assign o_gnt          = gnt;
  assign o_lock_timeout = timeout;

  // Read tracking: one-hot requester tag per issued read, shifted RD_LAT deep.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        rd_pipe[i] <= {NREQ{1'b0}};
      end
    end else begin
      rd_pipe[0] <= gnt & ~i_we;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  // Arbitration FSM: round-robin pointer, lock ownership and watchdog.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= {PW{1'b0}};
      owner    <= {PW{1'b0}};
      lock_cnt <= {LOCK_CNT_W{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (|gnt) begin
            rr_ptr <= PW'(wrap_inc(int'(pick_idx), NREQ));
            if (i_lock[pick_idx]) begin
              state    <= ST_LOCKED;
              owner    <= pick_idx;
              lock_cnt <= {LOCK_CNT_W{1'b0}};
            end
          end
        end
        ST_LOCKED: begin
          if (timeout) begin
            state    <= ST_IDLE;
            lock_cnt <= {LOCK_CNT_W{1'b0}};
          end else begin
            lock_cnt <= lock_cnt + {{(LOCK_CNT_W-1){1'b0}}, 1'b1};
            // Dropping i_lock ends the burst whether or not the owner
            // made a final access this cycle. rr_ptr already points past
            // the owner, so the others are next in line.
            if (!i_lock[owner]) begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
